// File: rtl/instr_aligner_pkg.sv
// Shared definitions for the fetch alignment stage and the decompressor.
//   OPC_QUAD_32   : low two bits that mark a full-width (32-bit) instruction
//   INST_W/HALF_W : instruction word and halfword widths
//   is_compressed : true when a halfword starts a 16-bit instruction
package instr_aligner_pkg;

    localparam logic [1:0] OPC_QUAD_32 = 2'b11;
    localparam int         INST_W      = 32;
    localparam int         HALF_W      = 16;

    function automatic logic is_compressed(input logic [HALF_W-1:0] half);
        return half[1:0] != OPC_QUAD_32;
    endfunction

endpackage

// File: rtl/instr_aligner.sv
// Fetch-side alignment stage, directly upstream of the decompressor.
// Splits word-aligned 32-bit fetch data into 16/32-bit instructions, which
// may straddle word boundaries, and tags each with its PC and a compressed flag.
//
// Optional feature macro: INSTR_ALIGNER_COMPRESSED_EN
//   defined   : halfword hold/skip logic, halfword-aligned redirects
//   undefined : every fetched word is emitted as-is, inst_compressed tied 0
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc   flush and refetch from redirect_pc
//   fetch_addr                    word address of the word expected on fetch_data
//   fetch_valid, fetch_data       memory response for fetch_addr
//   fetch_ready                   aligner accepts fetch_data this cycle
//   inst_valid, inst_ready        output handshake
//   inst_data, inst_pc            instruction (16-bit zero-extended) and its PC
//   inst_compressed               inst_data[1:0] != 2'b11
module instr_aligner
    import instr_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       fetch_addr,
    input  logic              fetch_valid,
    input  logic [INST_W-1:0] fetch_data,
    output logic              fetch_ready,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [31:0]       inst_pc,
    output logic              inst_compressed
);

    logic              r_inst_valid;
    logic [INST_W-1:0] r_inst_data;
    logic [31:0]       r_inst_pc;
    logic [31:0]       r_fetch_addr;

    logic w_slot_free;
    logic w_fetch_hs;
    logic w_unused;

    assign w_slot_free = !r_inst_valid || inst_ready;
    assign w_fetch_hs  = fetch_valid && fetch_ready;

    assign fetch_addr = r_fetch_addr;
    assign inst_valid = r_inst_valid;
    assign inst_data  = r_inst_data;
    assign inst_pc    = r_inst_pc;

`ifdef INSTR_ALIGNER_COMPRESSED_EN
    logic              r_hold_valid;
    logic [HALF_W-1:0] r_hold_half;
    logic [31:0]       r_hold_pc;
    logic              r_skip;
    logic              r_inst_comp;
    logic              w_hold_comp;

    assign w_hold_comp     = r_hold_valid && is_compressed(r_hold_half);
    // A held 16-bit instruction is emitted without consuming a fetch word.
    assign fetch_ready     = w_slot_free && !redirect_valid && !w_hold_comp;
    assign inst_compressed = r_inst_comp;
    assign w_unused        = redirect_pc[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_inst_pc    <= '0;
            r_inst_comp  <= 1'b0;
            r_fetch_addr <= {RESET_PC[31:2], 2'b00};
            r_hold_valid <= 1'b0;
            r_hold_half  <= '0;
            r_hold_pc    <= '0;
            r_skip       <= RESET_PC[1];
        end else if (redirect_valid) begin
            r_inst_valid <= 1'b0;
            r_hold_valid <= 1'b0;
            r_fetch_addr <= {redirect_pc[31:2], 2'b00};
            r_skip       <= redirect_pc[1];
        end else if (w_slot_free) begin
            r_inst_valid <= 1'b0;
            if (w_hold_comp) begin
                r_inst_valid <= 1'b1;
                r_inst_data  <= {16'b0, r_hold_half};
                r_inst_pc    <= r_hold_pc;
                r_inst_comp  <= 1'b1;
                r_hold_valid <= 1'b0;
            end else if (w_fetch_hs) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
                // Upper half is retained by default; only a fully aligned
                // 32-bit instruction leaves the hold empty.
                r_hold_valid <= 1'b1;
                r_hold_half  <= fetch_data[31:16];
                r_hold_pc    <= r_fetch_addr + 32'd2;
                if (r_hold_valid) begin
                    // Straddling 32-bit instruction: held half is the low half.
                    r_inst_valid <= 1'b1;
                    r_inst_data  <= {fetch_data[15:0], r_hold_half};
                    r_inst_pc    <= r_hold_pc;
                    r_inst_comp  <= 1'b0;
                end else if (r_skip) begin
                    r_skip <= 1'b0;
                end else if (is_compressed(fetch_data[15:0])) begin
                    r_inst_valid <= 1'b1;
                    r_inst_data  <= {16'b0, fetch_data[15:0]};
                    r_inst_pc    <= r_fetch_addr;
                    r_inst_comp  <= 1'b1;
                end else begin
                    r_inst_valid <= 1'b1;
                    r_inst_data  <= fetch_data;
                    r_inst_pc    <= r_fetch_addr;
                    r_inst_comp  <= 1'b0;
                    r_hold_valid <= 1'b0;
                end
            end
        end
    end
`else
    assign fetch_ready     = w_slot_free && !redirect_valid;
    assign inst_compressed = 1'b0;
    assign w_unused        = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_inst_pc    <= '0;
            r_fetch_addr <= {RESET_PC[31:2], 2'b00};
        end else if (redirect_valid) begin
            r_inst_valid <= 1'b0;
            r_fetch_addr <= {redirect_pc[31:2], 2'b00};
        end else if (w_slot_free) begin
            r_inst_valid <= w_fetch_hs;
            if (w_fetch_hs) begin
                r_inst_data  <= fetch_data;
                r_inst_pc    <= r_fetch_addr;
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_aligner.sv
module tb_instr_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_compressed;

    int vecs = 0;
    int errs = 0;

    instr_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_data(fetch_data), .fetch_ready(fetch_ready),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_compressed(inst_compressed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; registered outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Combinational outputs are sampled after freshly driven inputs settle.
    task automatic chk_rdy(input string tag, input logic exp);
        #1;
        chk(tag, {31'b0, fetch_ready}, {31'b0, exp});
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] d,
                            input logic [31:0] pc, input logic c);
        chk({tag, ".valid"}, {31'b0, inst_valid}, 32'd1);
        chk({tag, ".data"},  inst_data, d);
        chk({tag, ".pc"},    inst_pc, pc);
        chk({tag, ".comp"},  {31'b0, inst_compressed}, {31'b0, c});
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        fetch_valid = 1'b0; fetch_data = '0; inst_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst.valid", {31'b0, inst_valid}, 32'd0);
        chk("rst.data", inst_data, 32'd0);
        chk("rst.pc", inst_pc, 32'd0);
        chk("rst.comp", {31'b0, inst_compressed}, 32'd0);
        chk("rst.faddr", fetch_addr, 32'h0);

        // Aligned 32-bit stream, one per cycle
        inst_ready = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h0050_0093;
        chk_rdy("al.rdy", 1'b1);
        cyc();
        chk_inst("al0", 32'h0050_0093, 32'h0, 1'b0);
        chk("al0.faddr", fetch_addr, 32'h4);
        fetch_data = 32'h00A0_0113;
        cyc();
        chk_inst("al1", 32'h00A0_0113, 32'h4, 1'b0);
        chk("al1.faddr", fetch_addr, 32'h8);

        // Backpressure: slot held three cycles, word at 0x8 not lost
        inst_ready = 1'b0; fetch_data = 32'h0030_0193;
        chk_rdy("bp.rdy", 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_inst("bp.hold", 32'h00A0_0113, 32'h4, 1'b0);
            chk("bp.faddr", fetch_addr, 32'h8);
            chk("bp.rdy_hold", {31'b0, fetch_ready}, 32'd0);
        end
        inst_ready = 1'b1;
        chk_rdy("bp.rdy_rel", 1'b1);
        cyc();
        chk_inst("bp.next", 32'h0030_0193, 32'h8, 1'b0);
        chk("bp.faddr2", fetch_addr, 32'hC);
        fetch_valid = 1'b0;
        cyc();
        chk("drain.valid", {31'b0, inst_valid}, 32'd0);

        // Redirect to 0x102 while an instruction is pending
        fetch_valid = 1'b1; fetch_data = 32'h0040_0213;
        cyc();
        chk_inst("pend", 32'h0040_0213, 32'hC, 1'b0);
        inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        fetch_data = 32'hDEAD_BEEF;
        chk_rdy("rd.rdy", 1'b0);
        cyc();
        redirect_valid = 1'b0;
        chk("rd.valid", {31'b0, inst_valid}, 32'd0);
        chk("rd.faddr", fetch_addr, 32'h100);
        inst_ready = 1'b1;
`ifdef INSTR_ALIGNER_COMPRESSED_EN
        // Low half 0x4505 skipped; 0x0513 held as low half of a 32-bit inst
        fetch_data = 32'h0513_4505;
        chk_rdy("rd.rdy1", 1'b1);
        cyc();
        chk("rd.skip_valid", {31'b0, inst_valid}, 32'd0);
        chk("rd.faddr1", fetch_addr, 32'h104);
        fetch_data = 32'h4509_00A0;
        cyc();
        chk_inst("rd.first", 32'h00A0_0513, 32'h102, 1'b0);
        chk_rdy("rd.p1_rdy", 1'b0);
        cyc();
        chk_inst("rd.c", 32'h0000_4509, 32'h106, 1'b1);
        chk("rd.faddr2", fetch_addr, 32'h108);

        // Compressed pair at 0x0
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        fetch_data = 32'h4509_4505;
        cyc();
        chk_inst("cp0", 32'h0000_4505, 32'h0, 1'b1);
        chk_rdy("cp.rdy", 1'b0);
        cyc();
        chk_inst("cp1", 32'h0000_4509, 32'h2, 1'b1);
        chk("cp.faddr", fetch_addr, 32'h4);

        // Straddle at 0x0
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        fetch_data = 32'h0093_4505;
        cyc();
        chk_inst("st0", 32'h0000_4505, 32'h0, 1'b1);
        fetch_data = 32'h0000_0050;
        chk_rdy("st.rdy", 1'b1);
        cyc();
        chk_inst("st1", 32'h0050_0093, 32'h2, 1'b0);
        chk("st.faddr", fetch_addr, 32'h8);

        // Mid-operation reset with a held halfword (0x0000 @0x6)
        rst = 1'b1; fetch_valid = 1'b0;
        cyc();
        rst = 1'b0;
        chk("mr.valid", {31'b0, inst_valid}, 32'd0);
        chk("mr.faddr", fetch_addr, 32'h0);
        fetch_valid = 1'b1; fetch_data = 32'h0050_0093;
        chk_rdy("mr.rdy", 1'b1);
        cyc();
        chk_inst("mr.first", 32'h0050_0093, 32'h0, 1'b0);
`else
        // Word-aligned build: redirect_pc[1] ignored, whole word emitted
        fetch_data = 32'h0050_0293;
        chk_rdy("rd.rdy1", 1'b1);
        cyc();
        chk_inst("rd.first", 32'h0050_0293, 32'h100, 1'b0);
        chk("rd.faddr1", fetch_addr, 32'h104);

        // Mid-operation reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mr.valid", {31'b0, inst_valid}, 32'd0);
        chk("mr.faddr", fetch_addr, 32'h0);
        fetch_data = 32'h00A0_0113;
        chk_rdy("mr.rdy", 1'b1);
        cyc();
        chk_inst("mr.first", 32'h00A0_0113, 32'h0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
